// File: rtl/peripheral_gpio_filtered_wb.sv
`default_nettype none
// ============================================================================
//  Module      : peripheral_gpio_filtered_wb
//  Description : Wishbone GPIO slave with set/clear/toggle, aux-output muxing,
//                2-flop input synchronizer, prescaled glitch filter and
//                per-pin edge interrupts with W1C status.
//  Revision    : 1.0 - initial release
// ============================================================================
module peripheral_gpio_filtered_wb #(
    parameter int WB_ADDR_WIDTH = 8,
    parameter int WB_DATA_WIDTH = 32,
    parameter int GPIO_WIDTH    = 32,
    parameter int FILTER_DEPTH  = 3,
    parameter int DIV_WIDTH     = 16
) (
    input  logic                     wb_clk_i,
    input  logic                     wb_rst_i,
    input  logic                     wb_cyc_i,
    input  logic                     wb_stb_i,
    input  logic                     wb_we_i,
    input  logic [WB_ADDR_WIDTH-1:0] wb_adr_i,
    input  logic [31:0]              wb_dat_i,
    input  logic [3:0]               wb_sel_i,
    output logic [31:0]              wb_dat_o,
    output logic                     wb_ack_o,
    output logic                     wb_err_o,
    output logic                     wb_inta_o,
    input  logic [GPIO_WIDTH-1:0]    aux_i,
    input  logic [GPIO_WIDTH-1:0]    ext_pad_i,
    output logic [GPIO_WIDTH-1:0]    ext_pad_o,
    output logic [GPIO_WIDTH-1:0]    ext_padoe_o
);

    localparam logic [3:0] c_IN       = 4'h0;
    localparam logic [3:0] c_OUT      = 4'h1;
    localparam logic [3:0] c_OE       = 4'h2;
    localparam logic [3:0] c_OUT_SET  = 4'h3;
    localparam logic [3:0] c_OUT_CLR  = 4'h4;
    localparam logic [3:0] c_OUT_TGL  = 4'h5;
    localparam logic [3:0] c_IRQ_EN   = 4'h6;
    localparam logic [3:0] c_RISE_EN  = 4'h7;
    localparam logic [3:0] c_FALL_EN  = 4'h8;
    localparam logic [3:0] c_IRQ_STAT = 4'h9;
    localparam logic [3:0] c_DEB_DIV  = 4'hA;
    localparam logic [3:0] c_AUX_SEL  = 4'hB;

    // The newest sample is compared combinationally, so only DEPTH-1 older ones are stored.
    localparam int         c_HIST      = FILTER_DEPTH - 1;
    localparam logic [3:0] c_FILL_FULL = 4'(FILTER_DEPTH - 1);

    generate
        if (WB_DATA_WIDTH != 32) begin : g_bad_data_width
            $error("peripheral_gpio_filtered_wb: WB_DATA_WIDTH must be 32");
        end
        if (GPIO_WIDTH < 1 || GPIO_WIDTH > 32) begin : g_bad_gpio_width
            $error("peripheral_gpio_filtered_wb: GPIO_WIDTH must be 1..32");
        end
        if (FILTER_DEPTH < 2 || FILTER_DEPTH > 8) begin : g_bad_filter_depth
            $error("peripheral_gpio_filtered_wb: FILTER_DEPTH must be 2..8");
        end
        if (DIV_WIDTH < 1 || DIV_WIDTH > 32) begin : g_bad_div_width
            $error("peripheral_gpio_filtered_wb: DIV_WIDTH must be 1..32");
        end
        if (WB_ADDR_WIDTH < 6) begin : g_bad_addr_width
            $error("peripheral_gpio_filtered_wb: WB_ADDR_WIDTH must be >= 6");
        end
    endgenerate

    logic                  r_ack, r_err, r_inta;
    logic [31:0]           r_dat;
    logic [GPIO_WIDTH-1:0] r_out, r_oe, r_irq_en, r_rise_en, r_fall_en, r_stat, r_aux_sel;
    logic [DIV_WIDTH-1:0]  r_div, r_div_cnt;
    logic [GPIO_WIDTH-1:0] r_sync1, r_sync2, r_filt, r_prev;
    logic [GPIO_WIDTH-1:0] r_hist [c_HIST];
    logic [3:0]            r_fill;

    logic                  w_upper_zero, w_req, w_hit, w_wr, w_div_wr, w_bypass, w_tick;
    logic [3:0]            w_idx;
    logic [31:0]           w_bmask, w_rdata;
    logic [GPIO_WIDTH-1:0] w_bm, w_wd, w_out_nxt, w_all1, w_all0, w_rise, w_fall, w_w1c;
    logic                  w_unused;

    generate
        if (WB_ADDR_WIDTH > 6) begin : g_upper
            assign w_upper_zero = ~|wb_adr_i[WB_ADDR_WIDTH-1:6];
        end else begin : g_no_upper
            assign w_upper_zero = 1'b1;
        end
    endgenerate

    assign w_unused = ^wb_adr_i[1:0];
    assign w_idx    = wb_adr_i[5:2];
    assign w_req    = wb_cyc_i & wb_stb_i & ~r_ack & ~r_err;
    assign w_hit    = w_upper_zero & (w_idx <= c_AUX_SEL);
    assign w_wr     = w_req & w_hit & wb_we_i;
    assign w_div_wr = w_wr & (w_idx == c_DEB_DIV);
    assign w_bmask  = {{8{wb_sel_i[3]}}, {8{wb_sel_i[2]}}, {8{wb_sel_i[1]}}, {8{wb_sel_i[0]}}};
    assign w_bm     = w_bmask[GPIO_WIDTH-1:0];
    assign w_wd     = wb_dat_i[GPIO_WIDTH-1:0];

    assign wb_ack_o    = r_ack;
    assign wb_err_o    = r_err;
    assign wb_dat_o    = r_dat;
    assign wb_inta_o   = r_inta;
    assign ext_pad_o   = (r_aux_sel & aux_i) | (~r_aux_sel & r_out);
    assign ext_padoe_o = r_oe;

    always_comb begin
        w_rdata = '0;
        case (w_idx)
            c_IN:       w_rdata[GPIO_WIDTH-1:0] = r_filt;
            c_OUT:      w_rdata[GPIO_WIDTH-1:0] = r_out;
            c_OE:       w_rdata[GPIO_WIDTH-1:0] = r_oe;
            c_IRQ_EN:   w_rdata[GPIO_WIDTH-1:0] = r_irq_en;
            c_RISE_EN:  w_rdata[GPIO_WIDTH-1:0] = r_rise_en;
            c_FALL_EN:  w_rdata[GPIO_WIDTH-1:0] = r_fall_en;
            c_IRQ_STAT: w_rdata[GPIO_WIDTH-1:0] = r_stat;
            c_DEB_DIV:  w_rdata[DIV_WIDTH-1:0]  = r_div;
            c_AUX_SEL:  w_rdata[GPIO_WIDTH-1:0] = r_aux_sel;
            default:    w_rdata = '0;
        endcase
    end

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            r_ack <= 1'b0;
            r_err <= 1'b0;
            r_dat <= '0;
        end else begin
            r_ack <= w_req & w_hit;
            r_err <= w_req & ~w_hit;
            r_dat <= (w_req & w_hit & ~wb_we_i) ? w_rdata : '0;
        end
    end

    // Set/clear/toggle act on the full word; only the plain OUT write honours byte enables.
    always_comb begin
        w_out_nxt = r_out;
        if (w_wr) begin
            case (w_idx)
                c_OUT:     w_out_nxt = (r_out & ~w_bm) | (w_wd & w_bm);
                c_OUT_SET: w_out_nxt = r_out | w_wd;
                c_OUT_CLR: w_out_nxt = r_out & ~w_wd;
                c_OUT_TGL: w_out_nxt = r_out ^ w_wd;
                default:   w_out_nxt = r_out;
            endcase
        end
    end

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            r_out     <= '0;
            r_oe      <= '0;
            r_irq_en  <= '0;
            r_rise_en <= '0;
            r_fall_en <= '0;
            r_div     <= '0;
            r_aux_sel <= '0;
        end else begin
            r_out <= w_out_nxt;
            if (w_wr) begin
                case (w_idx)
                    c_OE:      r_oe      <= (r_oe      & ~w_bm) | (w_wd & w_bm);
                    c_IRQ_EN:  r_irq_en  <= (r_irq_en  & ~w_bm) | (w_wd & w_bm);
                    c_RISE_EN: r_rise_en <= (r_rise_en & ~w_bm) | (w_wd & w_bm);
                    c_FALL_EN: r_fall_en <= (r_fall_en & ~w_bm) | (w_wd & w_bm);
                    c_AUX_SEL: r_aux_sel <= (r_aux_sel & ~w_bm) | (w_wd & w_bm);
                    c_DEB_DIV: r_div     <= (r_div & ~w_bmask[DIV_WIDTH-1:0]) |
                                            (wb_dat_i[DIV_WIDTH-1:0] & w_bmask[DIV_WIDTH-1:0]);
                    default:   ;
                endcase
            end
        end
    end

    assign w_bypass = (r_div == '0);
    assign w_tick   = ~w_bypass & (r_div_cnt == r_div);

    always_comb begin
        w_all1 = r_sync2;
        w_all0 = ~r_sync2;
        for (int i = 0; i < c_HIST; i++) begin
            w_all1 = w_all1 & r_hist[i];
            w_all0 = w_all0 & ~r_hist[i];
        end
    end

    // r_fill counts valid history entries since the last clear, so a freshly
    // cleared history cannot masquerade as a run of zeros.
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            r_sync1   <= '0;
            r_sync2   <= '0;
            r_filt    <= '0;
            r_div_cnt <= '0;
            r_fill    <= '0;
            for (int i = 0; i < c_HIST; i++) r_hist[i] <= '0;
        end else begin
            r_sync1 <= ext_pad_i;
            r_sync2 <= r_sync1;
            if (w_div_wr) begin
                r_div_cnt <= '0;
                r_fill    <= '0;
                for (int i = 0; i < c_HIST; i++) r_hist[i] <= '0;
            end else if (w_bypass) begin
                r_filt <= r_sync2;
            end else if (w_tick) begin
                r_div_cnt <= '0;
                r_hist[0] <= r_sync2;
                for (int i = 1; i < c_HIST; i++) r_hist[i] <= r_hist[i-1];
                if (r_fill != c_FILL_FULL) r_fill <= r_fill + 1'b1;
                else                       r_filt <= w_all1 | (r_filt & ~w_all0);
            end else begin
                r_div_cnt <= r_div_cnt + 1'b1;
            end
        end
    end

    assign w_rise = r_filt & ~r_prev & r_rise_en;
    assign w_fall = ~r_filt & r_prev & r_fall_en;
    assign w_w1c  = (w_wr && w_idx == c_IRQ_STAT) ? (w_wd & w_bm) : '0;

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            r_prev <= '0;
            r_stat <= '0;
            r_inta <= 1'b0;
        end else begin
            r_prev <= r_filt;
            r_stat <= (r_stat & ~w_w1c) | w_rise | w_fall;
            r_inta <= |(r_stat & r_irq_en);
        end
    end

endmodule
`default_nettype wire
